// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid boot-time check sequencer.
package sysid_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'hDEADBEEF;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5BF4559A;

endpackage

// File: rtl/sysid_stall_timer.sv
// 16-bit waitrequest stall counter; expired_o flags that the stall limit was reached.
module sysid_stall_timer
  import sysid_check_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time sequencer: reads sysid ID and timestamp words over Avalon-MM and
// reports pass/fail/timeout status. Runs once after reset and on each start.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] sysid_value,
  output logic [31:0] timestamp_value
);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] sysid_q, sysid_d;
  logic [31:0] ts_q, ts_d;
  logic        tmr_clr;
  logic        tmr_expired;

  sysid_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clr_i    (tmr_clr),
    .en_i     (read_q && avm_waitrequest),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | start;
    read_d    = read_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    sysid_d   = sysid_q;
    ts_d      = ts_q;
    tmr_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q || start) begin
          pend_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          tmr_clr   = 1'b1;
          read_d    = 1'b1;
          addr_d    = SYSID_ADDR_ID;
          state_d   = RD_ID;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          sysid_d = avm_readdata;
          tmr_clr = 1'b1;
          addr_d  = SYSID_ADDR_TS;
          state_d = RD_TS;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          read_d    = 1'b0;
          state_d   = DONE;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_d    = avm_readdata;
          read_d  = 1'b0;
          state_d = DONE;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          read_d    = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        id_ok_d = (sysid_q == EXPECTED_ID) && !timeout_q;
        ts_ok_d = (ts_q == EXPECTED_TS) && !timeout_q;
        state_d = IDLE;
      end
    endcase
    // busy is registered, so decode it from the state being entered
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b1;
      read_q    <= 1'b0;
      addr_q    <= SYSID_ADDR_ID;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      sysid_q   <= '0;
      ts_q      <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      sysid_q   <= sysid_d;
      ts_q      <= ts_d;
    end
  end

  assign avm_read        = read_q;
  assign avm_address     = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout         = timeout_q;
  assign sysid_value     = sysid_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with a small waitrequest-capable slave model.
module tb_sysid_check_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] sysid_value, timestamp_value;

  logic [31:0] slv_id = 32'hDEADBEEF;
  logic [31:0] slv_ts = 32'h5BF4559A;
  int          stall_cfg = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;
  logic        acc_addr[$];
  logic        prev_stall = 1'b0;
  logic        prev_addr = 1'b0;
  int          glitches = 0;

  int checks = 0;
  int errors = 0;

  sysid_check_ctrl #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .sysid_value    (sysid_value),
    .timestamp_value(timestamp_value)
  );

  always #5 clock = ~clock;

  assign avm_waitrequest = avm_read && (stuck || (wcnt < stall_cfg));
  assign avm_readdata    = avm_address ? slv_ts : slv_id;

  always @(posedge clock) begin
    if (avm_read && !avm_waitrequest) begin
      acc_addr.push_back(avm_address);
      wcnt <= 0;
    end else if (avm_read && avm_waitrequest) begin
      wcnt <= wcnt + 1;
    end
    if (prev_stall && avm_read && (avm_address != prev_addr)) glitches <= glitches + 1;
    prev_stall <= avm_read && avm_waitrequest;
    prev_addr  <= avm_address;
  end

  // Counts edges from the call until done is seen high; drops start after the first edge.
  task automatic wait_done(input int max, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < max) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      start = 1'b0;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++; if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000000", {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}); end
    checks++; if (sysid_value !== 32'h0) begin errors++; $display("FAIL reset_sysid got %h exp 0", sysid_value); end
    checks++; if (timestamp_value !== 32'h0) begin errors++; $display("FAIL reset_ts got %h exp 0", timestamp_value); end
    checks++; if (acc_addr.size() != 0) begin errors++; $display("FAIL reset_reads got %0d exp 0", acc_addr.size()); end
  endtask

  task automatic test_auto_check;
    int n; bit ok; int base;
    base = acc_addr.size();
    reset_n = 1'b1;
    wait_done(20, n, ok);
    checks++; if (!ok || n != 4) begin errors++; $display("FAIL auto_latency got %0d ok=%0d exp 4", n, ok); end
    checks++; if ({id_ok, ts_ok, timeout} !== 3'b110) begin errors++; $display("FAIL auto_flags got %b exp 110", {id_ok, ts_ok, timeout}); end
    checks++; if (sysid_value !== 32'hDEADBEEF) begin errors++; $display("FAIL auto_sysid got %h exp deadbeef", sysid_value); end
    checks++; if (timestamp_value !== 32'h5BF4559A) begin errors++; $display("FAIL auto_ts got %h exp 5bf4559a", timestamp_value); end
    checks++; if (acc_addr.size() != base + 2) begin errors++; $display("FAIL auto_reads got %0d exp %0d", acc_addr.size(), base + 2); end
    else begin
      checks++; if ({acc_addr[base], acc_addr[base+1]} !== 2'b01) begin
        errors++; $display("FAIL auto_addr_order got %b exp 01", {acc_addr[base], acc_addr[base+1]}); end
    end
    @(negedge clock);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL auto_done_pulse got %b exp 00", {done, busy}); end
  endtask

  task automatic test_bad_id;
    int n; bit ok;
    slv_id = 32'hDEADBEEE;
    start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    checks++; if ({busy, avm_read, avm_address, id_ok, ts_ok} !== 5'b11000) begin
      errors++; $display("FAIL start_entry got %b exp 11000", {busy, avm_read, avm_address, id_ok, ts_ok}); end
    wait_done(20, n, ok);
    checks++; if (!ok || n != 3) begin errors++; $display("FAIL badid_latency got %0d ok=%0d exp 3", n, ok); end
    checks++; if ({id_ok, ts_ok, timeout} !== 3'b010) begin errors++; $display("FAIL badid_flags got %b exp 010", {id_ok, ts_ok, timeout}); end
    checks++; if (sysid_value !== 32'hDEADBEEE) begin errors++; $display("FAIL badid_sysid got %h exp deadbeee", sysid_value); end
    slv_id = 32'hDEADBEEF;
  endtask

  task automatic test_wait_states;
    int n; bit ok; int base; int g0;
    stall_cfg = 3;
    base = acc_addr.size();
    g0 = glitches;
    start = 1'b1;
    wait_done(40, n, ok);
    checks++; if (!ok || n != 10) begin errors++; $display("FAIL wait_latency got %0d ok=%0d exp 10", n, ok); end
    checks++; if ({id_ok, ts_ok, timeout} !== 3'b110) begin errors++; $display("FAIL wait_flags got %b exp 110", {id_ok, ts_ok, timeout}); end
    checks++; if (glitches != g0) begin errors++; $display("FAIL wait_addr_stable got %0d changes exp 0", glitches - g0); end
    checks++; if (acc_addr.size() != base + 2) begin errors++; $display("FAIL wait_reads got %0d exp %0d", acc_addr.size(), base + 2); end
    stall_cfg = 0;
  endtask

  task automatic test_timeout;
    int n; bit ok; int base;
    stuck = 1'b1;
    slv_id = 32'h12345678;
    base = acc_addr.size();
    start = 1'b1;
    wait_done(40, n, ok);
    checks++; if (!ok || n != 7) begin errors++; $display("FAIL to_latency got %0d ok=%0d exp 7", n, ok); end
    checks++; if ({id_ok, ts_ok, timeout, avm_read} !== 4'b0010) begin
      errors++; $display("FAIL to_flags got %b exp 0010", {id_ok, ts_ok, timeout, avm_read}); end
    checks++; if (sysid_value !== 32'hDEADBEEF) begin errors++; $display("FAIL to_sysid_kept got %h exp deadbeef", sysid_value); end
    checks++; if (acc_addr.size() != base) begin errors++; $display("FAIL to_reads got %0d exp %0d", acc_addr.size(), base); end
    stuck = 1'b0;
    slv_id = 32'hDEADBEEF;
  endtask

  task automatic test_back_to_back;
    int nd; int p1; int p2;
    nd = 0; p1 = 0; p2 = 0;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clock); @(negedge clock);
      start = (c == 2 || c == 3);
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) p1 = c; else if (nd == 2) p2 = c;
      end
    end
    start = 1'b0;
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", nd); end
    checks++; if (p1 != 4 || p2 != 8) begin errors++; $display("FAIL b2b_done_pos got %0d,%0d exp 4,8", p1, p2); end
  endtask

  task automatic test_reset_mid;
    int n; bit ok;
    start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    @(posedge clock); @(negedge clock);
    checks++; if ({avm_read, avm_address, busy} !== 3'b111) begin
      errors++; $display("FAIL mid_rdts got %b exp 111", {avm_read, avm_address, busy}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout} !== 7'b0) begin
      errors++; $display("FAIL mid_async_ctrl got %b exp 0000000", {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}); end
    checks++; if (sysid_value !== 32'h0) begin errors++; $display("FAIL mid_async_sysid got %h exp 0", sysid_value); end
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(20, n, ok);
    checks++; if (!ok || n != 4) begin errors++; $display("FAIL mid_rerun_latency got %0d ok=%0d exp 4", n, ok); end
    checks++; if ({id_ok, ts_ok, timeout} !== 3'b110) begin errors++; $display("FAIL mid_rerun_flags got %b exp 110", {id_ok, ts_ok, timeout}); end
    checks++; if (sysid_value !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_rerun_sysid got %h exp deadbeef", sysid_value); end
  endtask

  initial begin
    test_reset();
    test_auto_check();
    test_bad_id();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
